// File: rtl/mod_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_mul_seq_if
// Description : Operand/result handshake bundle for the sequential modular
//               multiplier (valid/ready in, valid/ready out).
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_mul_seq_if #(
    parameter int W = 6
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         const_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, const_en, out_ready,
        input  in_ready, out_valid, out_z, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, const_en, out_ready,
        output in_ready, out_valid, out_z, out_err
    );
endinterface
`default_nettype wire

// File: rtl/mod_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_mul_seq
// Description : Sequential z = (a * b) mod M, one MSB-first double-and-add
//               step per cycle, runtime or constant (K) multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mul_seq #(
    parameter int W = 6,
    parameter int M = 47,
    parameter int K = 34
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mod_mul_seq_if.slave bus
);
    localparam int               c_CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [W:0]       c_MOD     = (W + 1)'(M);
    localparam logic [W-1:0]     c_KVAL    = W'(K);
    localparam logic [c_CW-1:0]  c_CNT_TOP = c_CW'(W - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE = c_CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [c_CW-1:0] r_cnt;
    logic            r_err;

    logic            w_accept;
    logic            w_err_in;
    logic [W:0]      w_dbl;
    logic [W:0]      w_sum;
    logic [W-1:0]    w_dbl_red;
    logic [W-1:0]    w_sum_red;
    logic [W-1:0]    w_step;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_err_in = ({1'b0, bus.in_a} >= c_MOD) ||
                      (!bus.const_en && ({1'b0, bus.in_b} >= c_MOD));

    // Both partial results stay below 2M, so one conditional subtract reduces each.
    assign w_dbl     = {r_acc, 1'b0};
    assign w_dbl_red = (w_dbl >= c_MOD) ? W'(w_dbl - c_MOD) : w_dbl[W-1:0];
    assign w_sum     = {1'b0, w_dbl_red} + {1'b0, r_a};
    assign w_sum_red = (w_sum >= c_MOD) ? W'(w_sum - c_MOD) : w_sum[W-1:0];
    assign w_step    = r_b[r_cnt] ? w_sum_red : w_dbl_red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next_state = S_RUN;
            S_RUN:   if (r_cnt == '0)   w_next_state = S_DONE;
            S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.out_err   = (r_state == S_DONE) && r_err;
        bus.out_z     = ((r_state == S_DONE) && !r_err) ? r_acc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.const_en ? c_KVAL : bus.in_b;
            r_acc <= '0;
            r_cnt <= c_CNT_TOP;
            r_err <= w_err_in;
        end else if (r_state == S_RUN) begin
            r_acc <= w_step;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mod_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_mul_seq
// Description : Directed plus random checks of mod_mul_seq against an
//               arithmetic (a*b) mod M reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mul_seq;
    localparam int W = 6;
    localparam int M = 47;
    localparam int K = 34;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mod_mul_seq_if #(.W(W)) bus ();

    mod_mul_seq #(.W(W), .M(M), .K(K)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input int a, input int b, input int ce);
        return (a >= M) || ((ce == 0) && (b >= M));
    endfunction

    function automatic int ref_z(input int a, input int b, input int ce);
        if (ref_err(a, b, ce)) return 0;
        return (a * ((ce != 0) ? K : b)) % M;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int a, input int b, input int ce);
        bus.in_a     = W'(a);
        bus.in_b     = W'(b);
        bus.const_en = (ce != 0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_b     = W'($urandom);
        bus.const_en = ~bus.const_en;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 3 * W) begin
            tick();
            n++;
        end
    endtask

    task automatic do_op(input int a, input int b, input int ce, input string tag);
        int n;
        check({tag, ".in_ready"}, bus.in_ready, 1);
        bus.out_ready = 1'b1;
        start_op(a, b, ce);
        check({tag, ".busy"}, bus.in_ready, 0);
        wait_valid(n);
        check({tag, ".latency"}, n, W);
        check({tag, ".z"}, bus.out_z, ref_z(a, b, ce));
        check({tag, ".err"}, bus.out_err, ref_err(a, b, ce));
        tick();
        check({tag, ".release"}, bus.out_valid, 0);
    endtask

    initial begin
        int n;
        int a;
        int b;
        int ce;
        int ez;
        int seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.const_en  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_z", bus.out_z, 0);
        check("rst.out_err", bus.out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(12, 20, 0, "basic");
        do_op(12, 63, 1, "const12");
        do_op(1, 5, 1, "const1");
        do_op(46, 46, 0, "b46x46");
        do_op(0, 46, 0, "b0x46");
        do_op(46, 1, 0, "b46x1");
        do_op(47, 3, 0, "err_a");
        do_op(5, 63, 0, "err_b");
        do_op(5, 63, 1, "const_b63");
        do_op(0, 0, 1, "zero_const");

        // Backpressure: result must hold and in_valid must be ignored
        bus.out_ready = 1'b0;
        start_op(30, 7, 0);
        wait_valid(n);
        check("bp.latency", n, W);
        ez = ref_z(30, 7, 0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_a     = W'($urandom);
            tick();
            check("bp.valid", bus.out_valid, 1);
            check("bp.z", bus.out_z, ez);
            check("bp.err", bus.out_err, 0);
            check("bp.in_ready", bus.in_ready, 0);
        end
        bus.in_a      = W'(12);
        bus.in_b      = W'(20);
        bus.const_en  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("bp.no_accept_in_done", bus.in_ready, 1);
        check("bp.drop_valid", bus.out_valid, 0);
        do_op(12, 20, 0, "bp.next");

        // Reset in the middle of RUN
        start_op(12, 20, 0);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstrun.out_valid", bus.out_valid, 0);
        check("rstrun.out_z", bus.out_z, 0);
        check("rstrun.in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("rstrun.stale_valid", seen, 0);
        do_op(12, 20, 0, "rstrun.fresh");

        // Reset while a result is held in DONE
        bus.out_ready = 1'b0;
        start_op(47, 3, 0);
        wait_valid(n);
        check("rstdone.err_before", bus.out_err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstdone.out_valid", bus.out_valid, 0);
        check("rstdone.out_err", bus.out_err, 0);
        check("rstdone.in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, M - 1));
            b  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, M - 1));
            ce = int'($urandom_range(0, 1));
            do_op(a, b, ce, $sformatf("rnd%0d(a=%0d,b=%0d,ce=%0d)", i, a, b, ce));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
